// File: rtl/piso_tx_ctrl.sv
// Parallel-in/serial-out transmit controller: valid/ready word intake, one bit per shift_en tick.
// Optional PISO_PARITY_EN appends an even-parity bit (XOR of the word) after the data bits.
module piso_tx_ctrl #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         shift_en,
  output logic         serial_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     sreg, sreg_nxt, sreg_shifted;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             final_bit, accept;
  logic             serial_out_nxt, ser_valid_nxt, done_nxt;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_nxt;
`endif

  // Zero-filling one-place shift toward the transmitted end
  always_comb begin
    sreg_shifted = MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
  end

  // State, shift register and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      serial_out <= serial_out_nxt;
      ser_valid  <= ser_valid_nxt;
      busy       <= ser_valid_nxt;
      done       <= done_nxt;
`ifdef PISO_PARITY_EN
      parity_q   <= parity_nxt;
`endif
    end
  end

  // Next-state, handshake and next-output logic
  always_comb begin
    state_nxt      = state;
    sreg_nxt       = sreg;
    bit_cnt_nxt    = bit_cnt;
    done_nxt       = 1'b0;
    serial_out_nxt = 1'b0;
    ser_valid_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_nxt     = parity_q;
    final_bit      = (state == PAR);
`else
    final_bit      = (state == SHIFT) && (bit_cnt == LAST_CNT);
`endif

    // Ready in IDLE, or on the tick that consumes the last bit of a frame
    in_ready = !reset && ((state == IDLE) || (final_bit && shift_en));
    accept   = in_valid && in_ready;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = SHIFT;
          sreg_nxt    = in_data;
          bit_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
          parity_nxt  = ^in_data;
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          sreg_nxt = sreg_shifted;
          if (bit_cnt != LAST_CNT) begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state_nxt = PAR;
`else
            done_nxt = 1'b1;
            if (accept) begin
              state_nxt   = SHIFT;
              sreg_nxt    = in_data;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt   = IDLE;
              sreg_nxt    = '0;
              bit_cnt_nxt = '0;
            end
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (shift_en) begin
          done_nxt = 1'b1;
          if (accept) begin
            state_nxt   = SHIFT;
            sreg_nxt    = in_data;
            bit_cnt_nxt = '0;
            parity_nxt  = ^in_data;
          end else begin
            state_nxt   = IDLE;
            sreg_nxt    = '0;
            bit_cnt_nxt = '0;
            parity_nxt  = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_nxt   = IDLE;
        sreg_nxt    = '0;
        bit_cnt_nxt = '0;
      end
    endcase

    // Registered outputs reflect the state being entered
    case (state_nxt)
      SHIFT: begin
        serial_out_nxt = MSB_FIRST ? sreg_nxt[N-1] : sreg_nxt[0];
        ser_valid_nxt  = 1'b1;
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        serial_out_nxt = parity_nxt;
        ser_valid_nxt  = 1'b1;
      end
`endif
      default: begin
        serial_out_nxt = 1'b0;
        ser_valid_nxt  = 1'b0;
      end
    endcase
  end

endmodule
